// File: rtl/receiver8.sv
// Slot-addressed serial byte receiver: collects eight addressed bits into a byte,
// holds it until acknowledged, and aborts a frame that goes idle for TIMEOUT cycles.
module receiver8 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iBit,
  input  logic       iValid,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       iAck,
  output logic [7:0] oData,
  output logic       oValid,
  output logic [7:0] oMask,
  output logic       oErr,
  output logic       oOvr,
  output logic       oTimeout
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [BYTE_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;

  logic [2:0]        slot;
  logic [BYTE_W-1:0] slot_bit;
  logic [BYTE_W-1:0] mask_set;

  assign slot     = {A, B, C};
  assign slot_bit = BYTE_W'(1) << slot;
  assign mask_set = mask_q | slot_bit;

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovr_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iValid) begin
          data_d[slot] = iBit;
          mask_d       = mask_set;
          cnt_d        = '0;
          state_d      = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (iValid) begin
          cnt_d = '0;
          if (mask_q[slot]) begin
            err_d = 1'b1;
          end else begin
            data_d[slot] = iBit;
            mask_d       = mask_set;
            if (mask_set == {BYTE_W{1'b1}}) begin
              state_d = S_HOLD;
              valid_d = 1'b1;
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Idle too long: drop the partial frame but keep data bits visible
          mask_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        ovr_d = iValid;
        if (iAck) begin
          mask_d  = '0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        mask_d  = '0;
        err_d   = 1'b0;
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign oData    = data_q;
  assign oMask    = mask_q;
  assign oValid   = valid_q;
  assign oErr     = err_q;
  assign oOvr     = ovr_q;
  assign oTimeout = tmo_q;

endmodule

// File: tb/tb_receiver8.sv
// Bench for receiver8: directed frame scenarios plus random traffic, all checked
// cycle by cycle against a frame-level reference model.
module tb_receiver8;

  localparam int unsigned TMO = 16;

  logic       clk;
  logic       rst_n;
  logic       iBit;
  logic       iValid;
  logic       A, B, C;
  logic       iAck;
  logic [7:0] oData;
  logic       oValid;
  logic [7:0] oMask;
  logic       oErr;
  logic       oOvr;
  logic       oTimeout;

  int n_checks;
  int n_fails;

  // Reference model: frame contents, phase (0 idle, 1 collecting, 2 holding)
  bit [7:0] m_data;
  bit [7:0] m_mask;
  bit       m_err;
  bit       m_ovr;
  bit       m_tmo;
  int       m_phase;
  int       m_idle;

  receiver8 #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iBit    (iBit),
    .iValid  (iValid),
    .A       (A),
    .B       (B),
    .C       (C),
    .iAck    (iAck),
    .oData   (oData),
    .oValid  (oValid),
    .oMask   (oMask),
    .oErr    (oErr),
    .oOvr    (oOvr),
    .oTimeout(oTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_mask = '0; m_err = 0; m_ovr = 0; m_tmo = 0;
    m_phase = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input int s, input bit ack);
    m_ovr = 0;
    m_tmo = 0;
    if (m_phase == 2) begin
      m_ovr = v;
      if (ack) begin
        m_phase = 0; m_mask = '0; m_err = 0;
      end
    end else if (v) begin
      m_idle = 0;
      if (m_mask[s]) m_err = 1;
      else begin
        m_data[s] = b;
        m_mask[s] = 1'b1;
      end
      m_phase = (m_mask == 8'hFF) ? 2 : 1;
    end else if (m_phase == 1) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_mask = '0; m_err = 0; m_tmo = 1; m_phase = 0; m_idle = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_data"},  32'(oData),    32'(m_data));
    check_eq({tag, "_mask"},  32'(oMask),    32'(m_mask));
    check_eq({tag, "_valid"}, 32'(oValid),   32'(m_phase == 2));
    check_eq({tag, "_err"},   32'(oErr),     32'(m_err));
    check_eq({tag, "_ovr"},   32'(oOvr),     32'(m_ovr));
    check_eq({tag, "_tmo"},   32'(oTimeout), 32'(m_tmo));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare after the edge
  task automatic cycle(input string tag, input bit v, input bit b, input int s, input bit ack);
    logic [2:0] sl;
    sl = 3'(s);
    iValid = v; iBit = b; {A, B, C} = sl; iAck = ack;
    @(posedge clk);
    model_step(v, b, s, ack);
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 0, 1'b0);
  endtask

  int order29[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  bit bits29[8]  = '{1, 0, 1, 1, 0, 0, 1, 0};
  int order30[8] = '{7, 3, 5, 0, 1, 6, 2, 4};

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; iBit = 0; iValid = 0; {A, B, C} = 3'd0; iAck = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    #10;

    // In-order frame with mixed bits
    for (int i = 0; i < 8; i++) cycle("inorder", 1'b1, bits29[i], order29[i], 1'b0);
    check_eq("inorder_byte", 32'(oData), 32'h4D);
    check_eq("inorder_full", 32'(oValid), 32'd1);
    cycle("inorder_ack", 1'b0, 1'b0, 0, 1'b1);
    check_eq("inorder_dropped", 32'(oValid), 32'd0);

    // Out-of-order frame, all ones
    for (int i = 0; i < 8; i++) cycle("ooo", 1'b1, 1'b1, order30[i], 1'b0);
    check_eq("ooo_byte", 32'(oData), 32'hFF);
    cycle("ooo_ack", 1'b0, 1'b0, 0, 1'b1);

    // Duplicate slot 2: first bit kept, error sticky through HOLD
    cycle("dup", 1'b1, 1'b1, 2, 1'b0);
    cycle("dup", 1'b1, 1'b0, 2, 1'b0);
    check_eq("dup_err", 32'(oErr), 32'd1);
    for (int s = 0; s < 8; s++) if (s != 2) cycle("dup", 1'b1, 1'b0, s, 1'b0);
    check_eq("dup_bit2", 32'(oData[2]), 32'd1);
    check_eq("dup_hold_err", 32'(oErr), 32'd1);
    cycle("dup_ack", 1'b0, 1'b0, 0, 1'b1);

    // Timeout after exactly TMO idle cycles
    for (int i = 0; i < 3; i++) cycle("tmo", 1'b1, 1'b1, i, 1'b0);
    idle_cycles("tmo", TMO - 1);
    check_eq("tmo_not_yet", 32'(oTimeout), 32'd0);
    idle_cycles("tmo", 1);
    check_eq("tmo_pulse", 32'(oTimeout), 32'd1);
    idle_cycles("tmo_after", 2);

    // Strobe on the would-be timeout edge wins
    for (int i = 0; i < 3; i++) cycle("tmo_win", 1'b1, 1'b0, i, 1'b0);
    idle_cycles("tmo_win", TMO - 1);
    cycle("tmo_win_strobe", 1'b1, 1'b1, 3, 1'b0);
    check_eq("tmo_win_none", 32'(oTimeout), 32'd0);
    check_eq("tmo_win_mask", 32'(oMask), 32'h0F);
    for (int s = 4; s < 8; s++) cycle("tmo_win", 1'b1, 1'b1, s, 1'b0);

    // HOLD: overrun alone, then overrun together with ack
    cycle("ovr", 1'b1, 1'b0, 5, 1'b0);
    check_eq("ovr_pulse", 32'(oOvr), 32'd1);
    cycle("ovr_ack", 1'b1, 1'b0, 6, 1'b1);
    check_eq("ovr_ack_data", 32'(oData), 32'hF8);
    check_eq("ovr_ack_valid", 32'(oValid), 32'd0);
    idle_cycles("ovr_after", 1);

    // Ack outside HOLD is ignored
    cycle("ack_idle", 1'b0, 1'b0, 0, 1'b1);
    cycle("ack_coll", 1'b1, 1'b1, 1, 1'b0);
    cycle("ack_coll", 1'b0, 1'b0, 0, 1'b1);

    // Asynchronous reset mid-frame
    for (int s = 2; s < 6; s++) cycle("rst_mid", 1'b1, 1'b1, s, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    iValid = 0; iAck = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_all("rst_release");
    for (int i = 0; i < 8; i++) cycle("post_rst", 1'b1, bits29[i], order30[i], 1'b0);
    check_eq("post_rst_valid", 32'(oValid), 32'd1);
    cycle("post_rst_ack", 1'b0, 1'b0, 0, 1'b1);

    // Random traffic with bursts of idleness to provoke timeouts
    for (int seg = 0; seg < 60; seg++) begin
      int pv;
      int len;
      pv  = (seg % 4 == 3) ? 2 : int'($urandom_range(30, 90));
      len = int'($urandom_range(5, 40));
      for (int i = 0; i < len; i++) begin
        bit v;
        bit b;
        bit k;
        int s;
        v = ($urandom_range(0, 99) < pv);
        b = 1'($urandom);
        s = int'($urandom_range(0, 7));
        k = ($urandom_range(0, 99) < 25);
        cycle("rand", v, b, s, k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
